// File: rtl/papuf_eval_ctrl_if.sv
// Bus bundle between the host, the PA-PUF array and papuf_eval_ctrl.
// Groups the request handshake, the response handshake and the array wires.
// Optional macro PAPUF_STABILITY_EN adds the resp_unstable signal.
interface papuf_eval_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_challenge;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
`ifdef PAPUF_STABILITY_EN
  logic [15:0] resp_unstable;
`endif
  logic [15:0] puf_challenge;
  logic        puf_pulse;
  logic [15:0] puf_response;

  // Host plus array side.
  modport master (
    output req_valid, req_challenge, resp_ready, puf_response,
    input  req_ready, resp_valid, resp_data, puf_challenge, puf_pulse
`ifdef PAPUF_STABILITY_EN
    , input resp_unstable
`endif
  );

  // Controller side.
  modport slave (
    input  req_valid, req_challenge, resp_ready, puf_response,
    output req_ready, resp_valid, resp_data, puf_challenge, puf_pulse
`ifdef PAPUF_STABILITY_EN
    , output resp_unstable
`endif
  );
endinterface

// File: rtl/papuf_eval_ctrl.sv
// papuf_eval_ctrl: evaluation sequencer for the 16-bit PA-PUF array.
// Accepts a challenge, runs NUM_EVAL setup/pulse/settle/capture rounds and
// returns the per-bit majority vote of the captured responses.
// Optional macro PAPUF_STABILITY_EN adds resp_unstable (evaluations disagreed).
module papuf_eval_ctrl #(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int NUM_EVAL   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  papuf_eval_ctrl_if.slave  bus,
  output logic              busy
);

  localparam int DATA_W  = 16;
  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
  localparam int PH_W    = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PH_W-1:0]     r_phase;
  logic [3:0]          r_eval;
  logic [3:0]          r_vote [DATA_W];
  logic [DATA_W-1:0]   r_chal;
  logic                r_pulse;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic                w_accept;
  logic                w_handshake;
`ifdef PAPUF_STABILITY_EN
  logic [DATA_W-1:0]   r_resp_unstable;
`endif

  // Majority decision for one bit's vote count.
  function automatic logic majority(input logic [3:0] votes);
    return (votes > 4'(NUM_EVAL / 2));
  endfunction

`ifdef PAPUF_STABILITY_EN
  // A bit is unstable when the evaluations did not all agree.
  function automatic logic disagree(input logic [3:0] votes);
    return (votes != 4'd0) && (votes < 4'(NUM_EVAL));
  endfunction
`endif

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_handshake = (r_state == S_DONE) && r_resp_valid && bus.resp_ready;

  // Next-state decode: each timed phase advances when its counter hits the end.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.req_valid) w_next = S_SETUP;
      S_SETUP:   if (r_phase == PH_W'(SETUP_CYC - 1)) w_next = S_PULSE;
      S_PULSE:   if (r_phase == PH_W'(PULSE_CYC - 1)) w_next = S_SETTLE;
      S_SETTLE:  if (r_phase == PH_W'(SETTLE_CYC - 1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = (r_eval == 4'(NUM_EVAL - 1)) ? S_DONE : S_SETUP;
      S_DONE:    if (r_resp_valid && bus.resp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register, phase counter and registered (glitch-free) pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pulse <= (w_next == S_PULSE);
      if (w_next != r_state) begin
        r_phase <= '0;
      end else if ((r_state == S_SETUP) || (r_state == S_PULSE) || (r_state == S_SETTLE)) begin
        r_phase <= r_phase + PH_W'(1);
      end
    end
  end

  // Challenge latch, evaluation counter and per-bit vote accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chal <= '0;
      r_eval <= '0;
      for (int i = 0; i < DATA_W; i++) r_vote[i] <= '0;
    end else if (w_accept) begin
      r_chal <= bus.req_challenge;
      r_eval <= '0;
      for (int i = 0; i < DATA_W; i++) r_vote[i] <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_eval <= r_eval + 4'd1;
      for (int i = 0; i < DATA_W; i++) r_vote[i] <= r_vote[i] + {3'b000, bus.puf_response[i]};
    end
  end

  // Resolve the vote once in DONE (after the final capture has landed) and hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
`ifdef PAPUF_STABILITY_EN
      r_resp_unstable <= '0;
`endif
    end else if (w_handshake) begin
      r_resp_valid <= 1'b0;
    end else if ((r_state == S_DONE) && !r_resp_valid) begin
      r_resp_valid <= 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
        r_resp_data[i]     <= majority(r_vote[i]);
`ifdef PAPUF_STABILITY_EN
        r_resp_unstable[i] <= disagree(r_vote[i]);
`endif
      end
    end
  end

  assign bus.req_ready     = (r_state == S_IDLE);
  assign busy              = (r_state != S_IDLE);
  assign bus.puf_challenge = r_chal;
  assign bus.puf_pulse     = r_pulse;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_resp_data;
`ifdef PAPUF_STABILITY_EN
  assign bus.resp_unstable = r_resp_unstable;
`endif

endmodule

// File: tb/tb_papuf_eval_ctrl.sv
// Testbench for papuf_eval_ctrl: default-parameter instance plus a
// single-shot instance (NUM_EVAL=1, all phases 1 cycle). Expected responses
// are modelled from the driven capture table and queued at acceptance.
module tb_papuf_eval_ctrl;

  localparam int NE  = 5;
  localparam int LAT = 76;

  logic clk;
  logic rst_n;
  logic busy0;
  logic busy1;

  int errors;
  int checks;

  logic [15:0] tbl [NE];
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];

  papuf_eval_ctrl_if b0 ();
  papuf_eval_ctrl_if b1 ();

  papuf_eval_ctrl u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0),
    .busy  (busy0)
  );

  papuf_eval_ctrl #(
    .SETUP_CYC  (1),
    .PULSE_CYC  (1),
    .SETTLE_CYC (1),
    .NUM_EVAL   (1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: {unstable, majority} over the first ne table entries.
  function automatic logic [31:0] model(input int ne);
    logic [15:0] d;
    logic [15:0] u;
    int c;
    for (int i = 0; i < 16; i++) begin
      c = 0;
      for (int k = 0; k < ne; k++) c += int'(tbl[k][i]);
      d[i] = (c > ne / 2);
      u[i] = (c > 0) && (c < ne);
    end
    return {u, d};
  endfunction

  task automatic compare_out0();
    logic [31:0] e;
    if (sb0.size() == 0) begin
      chk("sb0_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb0.pop_front();
      chk("resp_data", {16'h0, b0.resp_data}, {16'h0, e[15:0]});
`ifdef PAPUF_STABILITY_EN
      chk("resp_unstable", {16'h0, b0.resp_unstable}, {16'h0, e[31:16]});
`endif
    end
  endtask

  // Runs edges until resp_valid (or abort during pulse number abort_pulse).
  task automatic wait_resp(input int abort_pulse, output int lat, output bit aborted);
    int plen;
    int npulse;
    lat = 0;
    plen = 0;
    npulse = 0;
    aborted = 1'b0;
    while (!b0.resp_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (b0.puf_pulse) begin
        if (plen == 0 && npulse < NE) b0.puf_response = tbl[npulse];
        plen++;
        if (npulse == abort_pulse && plen == 2) begin
          #2;
          rst_n = 1'b0;
          #1;
          chk("rst_pulse_low", {31'd0, b0.puf_pulse}, 32'd0);
          chk("rst_busy_low", {31'd0, busy0}, 32'd0);
          chk("rst_no_valid", {31'd0, b0.resp_valid}, 32'd0);
          chk("rst_req_ready", {31'd0, b0.req_ready}, 32'd1);
          @(negedge clk);
          rst_n = 1'b1;
          aborted = 1'b1;
          return;
        end
      end else if (plen > 0) begin
        chk("pulse_len", plen, 32'd4);
        npulse++;
        plen = 0;
      end
    end
    chk("pulse_count", npulse, NE);
  endtask

  task automatic do_req(input logic [15:0] ch, input int hold);
    int lat;
    int bad;
    bit ab;
    logic [15:0] d0;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, b0.req_ready}, 32'd1);
    b0.req_valid = 1'b1;
    b0.req_challenge = ch;
    @(posedge clk);
    #1;
    b0.req_valid = 1'b0;
    b0.req_challenge = ~ch;
    sb0.push_back(model(NE));
    chk("chal_latched", {16'h0, b0.puf_challenge}, {16'h0, ch});
    chk("busy_after_accept", {31'd0, busy0}, 32'd1);
    wait_resp(-1, lat, ab);
    chk("latency", lat, LAT);
    chk("chal_stable", {16'h0, b0.puf_challenge}, {16'h0, ch});
    chk("resp_valid", {31'd0, b0.resp_valid}, 32'd1);
    compare_out0();
    d0 = b0.resp_data;
    if (hold > 0) begin
      b0.req_valid = 1'b1;
      b0.req_challenge = 16'hBEEF;
      bad = 0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!b0.resp_valid || b0.resp_data !== d0 || b0.req_ready || !busy0 ||
            b0.puf_challenge !== ch) bad++;
      end
      chk("hold_stable", bad, 32'd0);
      b0.req_valid = 1'b0;
    end
    b0.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    b0.resp_ready = 1'b0;
    chk("valid_drop", {31'd0, b0.resp_valid}, 32'd0);
    chk("idle_after", {31'd0, busy0}, 32'd0);
    chk("data_held", {16'h0, b0.resp_data}, {16'h0, d0});
  endtask

  initial begin
    int lat;
    bit ab;
    logic [31:0] e;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    b0.req_valid = 1'b0;
    b0.req_challenge = 16'h0;
    b0.resp_ready = 1'b0;
    b0.puf_response = 16'h0;
    b1.req_valid = 1'b0;
    b1.req_challenge = 16'h0;
    b1.resp_ready = 1'b0;
    b1.puf_response = 16'h00F0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, b0.req_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_valid", {31'd0, b0.resp_valid}, 32'd0);
    chk("reset_pulse", {31'd0, b0.puf_pulse}, 32'd0);
    chk("reset_chal", {16'h0, b0.puf_challenge}, 32'd0);
    chk("reset_data", {16'h0, b0.resp_data}, 32'd0);
    chk("reset_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Constant response.
    for (int k = 0; k < NE; k++) tbl[k] = 16'hA5C3;
    do_req(16'h1234, 0);

    // Alternating all-ones / all-zeros captures.
    for (int k = 0; k < NE; k++) tbl[k] = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
    do_req(16'h5A5A, 0);

    // Random captures, consumer stalls 20 cycles with a second request pending.
    for (int k = 0; k < NE; k++) tbl[k] = 16'($urandom);
    do_req(16'hC0DE, 20);

    // Reset during the pulse of evaluation 3, then a full request.
    for (int k = 0; k < NE; k++) tbl[k] = 16'($urandom);
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.req_challenge = 16'h3C3C;
    @(posedge clk);
    #1;
    b0.req_valid = 1'b0;
    sb0.push_back(model(NE));
    wait_resp(2, lat, ab);
    chk("abort_taken", {31'd0, ab}, 32'd1);
    if (ab) void'(sb0.pop_back());
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_valid", {31'd0, b0.resp_valid}, 32'd0);
    chk("abort_idle", {31'd0, busy0}, 32'd0);
    do_req(16'h9876, 0);

    // Back-to-back with resp_ready tied high and req_valid held.
    for (int k = 0; k < NE; k++) tbl[k] = 16'($urandom);
    @(negedge clk);
    b0.resp_ready = 1'b1;
    b0.req_valid = 1'b1;
    b0.req_challenge = 16'h0F0F;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      sb0.push_back(model(NE));
      chk("b2b_accept", {31'd0, busy0}, 32'd1);
      wait_resp(-1, lat, ab);
      chk("b2b_latency", lat, LAT);
      compare_out0();
      @(posedge clk);
      #1;
      chk("b2b_idle_gap", {31'd0, busy0}, 32'd0);
      chk("b2b_valid_drop", {31'd0, b0.resp_valid}, 32'd0);
    end
    b0.req_valid = 1'b0;
    b0.resp_ready = 1'b0;

    // Single-shot instance.
    tbl[0] = 16'h00F0;
    @(negedge clk);
    b1.req_valid = 1'b1;
    b1.req_challenge = 16'h7777;
    @(posedge clk);
    #1;
    b1.req_valid = 1'b0;
    sb1.push_back(model(1));
    lat = 0;
    while (!b1.resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ne1_latency", lat, 32'd5);
    if (sb1.size() == 0) begin
      chk("sb1_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb1.pop_front();
      chk("ne1_data", {16'h0, b1.resp_data}, {16'h0, e[15:0]});
`ifdef PAPUF_STABILITY_EN
      chk("ne1_unstable", {16'h0, b1.resp_unstable}, {16'h0, e[31:16]});
`endif
    end
    b1.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    b1.resp_ready = 1'b0;
    chk("ne1_idle", {31'd0, busy1}, 32'd0);
    chk("sb0_drained", sb0.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
